// File: rtl/dcache_data_pkg.sv
// Shared types and widths for the L1 data-array pipe.
// Lane request and response bundles.
package dcache_data_pkg;

  localparam int WAYS   = 8;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [WAYS-1:0]   way_en;
    logic [ADDR_W-1:0] addr;
    logic              valid;
  } lane_req_t;

  typedef struct packed {
    logic [1:0][DATA_W-1:0] data;
    logic [1:0]             lane_valid;
  } resp_t;

endpackage

// File: rtl/dcache_data_if.sv
// Request, SRAM and response signals of the data-array pipe.
// slave = pipe side, master = arbiter/array/consumer side.
interface dcache_data_if;
  import dcache_data_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [WAYS-1:0]        req_way_en_0;
  logic [WAYS-1:0]        req_way_en_1;
  logic [ADDR_W-1:0]      req_addr_0;
  logic [ADDR_W-1:0]      req_addr_1;
  logic                   req_lane_valid_0;
  logic                   req_lane_valid_1;
  logic [DATA_W-1:0]      req_wdata;

  logic                   sram_en;
  logic                   sram_we;
  logic [WAYS-1:0]        sram_way_en_0;
  logic [WAYS-1:0]        sram_way_en_1;
  logic [ADDR_W-1:0]      sram_addr_0;
  logic [ADDR_W-1:0]      sram_addr_1;
  logic [DATA_W-1:0]      sram_wdata;
  logic [WAYS*DATA_W-1:0] sram_rdata_0;
  logic [WAYS*DATA_W-1:0] sram_rdata_1;

  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_W-1:0]      resp_data_0;
  logic [DATA_W-1:0]      resp_data_1;
  logic                   resp_lane_valid_0;
  logic                   resp_lane_valid_1;

  modport slave (
    input  req_valid, req_write,
    input  req_way_en_0, req_way_en_1,
    input  req_addr_0, req_addr_1,
    input  req_lane_valid_0, req_lane_valid_1,
    input  req_wdata,
    output req_ready,
    output sram_en, sram_we,
    output sram_way_en_0, sram_way_en_1,
    output sram_addr_0, sram_addr_1,
    output sram_wdata,
    input  sram_rdata_0, sram_rdata_1,
    output resp_valid,
    input  resp_ready,
    output resp_data_0, resp_data_1,
    output resp_lane_valid_0, resp_lane_valid_1
  );

  modport master (
    output req_valid, req_write,
    output req_way_en_0, req_way_en_1,
    output req_addr_0, req_addr_1,
    output req_lane_valid_0, req_lane_valid_1,
    output req_wdata,
    input  req_ready,
    input  sram_en, sram_we,
    input  sram_way_en_0, sram_way_en_1,
    input  sram_addr_0, sram_addr_1,
    input  sram_wdata,
    output sram_rdata_0, sram_rdata_1,
    input  resp_valid,
    output resp_ready,
    input  resp_data_0, resp_data_1,
    input  resp_lane_valid_0, resp_lane_valid_1
  );

endinterface

// File: rtl/dcache_resp_queue.sv
// In-order response FIFO with registered head and valid.
// Head register is reloaded from next-state storage each cycle.
module dcache_resp_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next storage, pointers, count and registered head.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    pop     = pop_i & valid_q;
    if (push_i) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wrap_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = wrap_inc(rptr_q);
    end
    count_d = count_q + CW'(push_i) - CW'(pop);
    valid_d = (count_d != '0);
    head_d  = mem_d[rptr_d];
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign count_o = count_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push_i && (count_q == CW'(DEPTH)) && !pop)
  );

endmodule

// File: rtl/dcache_data_array_pipe.sv
// Data-array access stage: drives the SRAM, way-selects
// read data a cycle later and queues it under credit control.
module dcache_data_array_pipe
  import dcache_data_pkg::*;
#(
  parameter int RESP_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  dcache_data_if.slave bus
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int RW = $bits(resp_t);

  lane_req_t            lane_0, lane_1;
  logic                 fire, req_ready, pop_ok;
  logic [OW-1:0]        outstanding;
  logic [CW-1:0]        q_count;
  logic                 q_valid;
  logic [RW-1:0]        q_head_raw;
  resp_t                q_head, s1_resp;
  logic                 s1_valid_q, s1_valid_d;
  logic [1:0]           s1_lv_q, s1_lv_d;
  logic [1:0][WAYS-1:0] s1_way_q, s1_way_d;
  logic [1:0][WAYS*DATA_W-1:0] rdata;

  assign rdata[0] = bus.sram_rdata_0;
  assign rdata[1] = bus.sram_rdata_1;

  // Credit check, accept and per-lane gating of the request.
  always_comb begin
    pop_ok      = q_valid & bus.resp_ready;
    outstanding = OW'(s1_valid_q) + OW'(q_count)
                - OW'(pop_ok);
    req_ready   = reset
                & (outstanding < OW'(RESP_DEPTH));
    fire        = bus.req_valid & req_ready;
    lane_0 = '{
      way_en: bus.req_way_en_0,
      addr:   bus.req_addr_0,
      valid:  fire & bus.req_lane_valid_0
    };
    lane_1 = '{
      way_en: bus.req_way_en_1,
      addr:   bus.req_addr_1,
      valid:  fire & ~bus.req_write
            & bus.req_lane_valid_1
    };
    s1_valid_d  = fire & ~bus.req_write;
    s1_lv_d     = {lane_1.valid, lane_0.valid};
    s1_way_d[0] = lane_0.valid ? lane_0.way_en : '0;
    s1_way_d[1] = lane_1.valid ? lane_1.way_en : '0;
  end

  // Stage-1 record of a read waiting for array data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_lv_q    <= '0;
      s1_way_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lv_q    <= s1_lv_d;
      s1_way_q   <= s1_way_d;
    end
  end

  // Way select: OR of every enabled way per lane.
  always_comb begin
    s1_resp = '0;
    for (int l = 0; l < 2; l++) begin
      s1_resp.lane_valid[l] = s1_lv_q[l];
      for (int w = 0; w < WAYS; w++) begin
        if (s1_lv_q[l] && s1_way_q[l][w]) begin
          s1_resp.data[l] = s1_resp.data[l]
                          | rdata[l][w*DATA_W +: DATA_W];
        end
      end
    end
  end

  dcache_resp_queue #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (RW)
  ) u_resp_q (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (s1_valid_q),
    .data_i  (s1_resp),
    .pop_i   (bus.resp_ready),
    .valid_o (q_valid),
    .data_o  (q_head_raw),
    .count_o (q_count)
  );

  assign q_head = resp_t'(q_head_raw);

  assign bus.req_ready     = req_ready;
  assign bus.sram_en       = fire;
  assign bus.sram_we       = fire & bus.req_write;
  assign bus.sram_way_en_0 = lane_0.valid ? lane_0.way_en : '0;
  assign bus.sram_way_en_1 = lane_1.valid ? lane_1.way_en : '0;
  assign bus.sram_addr_0   = lane_0.valid ? lane_0.addr : '0;
  assign bus.sram_addr_1   = lane_1.valid ? lane_1.addr : '0;
  assign bus.sram_wdata    = lane_0.valid ? bus.req_wdata : '0;

  assign bus.resp_valid        = q_valid;
  assign bus.resp_data_0       = q_head.data[0];
  assign bus.resp_data_1       = q_head.data[1];
  assign bus.resp_lane_valid_0 = q_head.lane_valid[0];
  assign bus.resp_lane_valid_1 = q_head.lane_valid[1];

endmodule
